// File: rtl/rx_stream_pkg.sv
// Shared definitions for the multi-channel RX stream arbiter: tagged word
// layout, channel limits and the word packing helper.
package rx_stream_pkg;

    localparam int unsigned MAX_CH     = 4;
    localparam int unsigned EXT_W      = 13;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned CH_ID_W    = $clog2(MAX_CH);

    localparam int unsigned MARKER_BIT = 31;
    localparam int unsigned CH_ID_LSB  = 29;
    localparam int unsigned I_LSB      = 16;
    localparam int unsigned DROP_BIT   = 14;
    localparam int unsigned Q_LSB      = 0;

    localparam logic        MARKER     = 1'b1;

    typedef struct packed {
        logic               marker;
        logic [CH_ID_W-1:0] ch_id;
        logic [EXT_W-1:0]   i_s;
        logic               rsvd_hi;
        logic               drop;
        logic               rsvd_lo;
        logic [EXT_W-1:0]   q_s;
    } rx_word_t;

    // Build a tagged word; reserved bits stay zero.
    function automatic rx_word_t pack_word(
        input logic [CH_ID_W-1:0] ch_id,
        input logic [EXT_W-1:0]   i_s,
        input logic               drop,
        input logic [EXT_W-1:0]   q_s
    );
        logic [WORD_W-1:0] w;
        w                          = '0;
        w[MARKER_BIT]              = MARKER;
        w[CH_ID_LSB +: CH_ID_W]    = ch_id;
        w[I_LSB +: EXT_W]          = i_s;
        w[DROP_BIT]                = drop;
        w[Q_LSB +: EXT_W]          = q_s;
        return rx_word_t'(w);
    endfunction

endpackage

// File: rtl/rx_stream_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// then moves the pointer just past the winner when the grant is accepted.
module rr_arbiter
    import rx_stream_pkg::*;
#(
    parameter int unsigned NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              accept,
    output logic [NUM_CH-1:0] grant_c
);

    localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_CH - 1);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] idx_c;
    logic [PTR_W-1:0] grant_idx_c;
    logic             found_c;

    // Walk the channels starting at the pointer, wrapping modulo NUM_CH.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = ptr;
        found_c     = 1'b0;
        idx_c       = ptr;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            if (!found_c && req[idx_c]) begin
                found_c        = 1'b1;
                grant_c[idx_c] = 1'b1;
                grant_idx_c    = idx_c;
            end
            idx_c = (idx_c == LAST_IDX) ? '0 : idx_c + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept && found_c) begin
            ptr <= (grant_idx_c == LAST_IDX) ? '0 : grant_idx_c + PTR_W'(1);
        end
    end

endmodule

// File: rtl/rx_stream_arbiter.sv
// Merges up to four I/Q sample streams into one tagged word stream with
// round-robin arbitration, per-channel drop counting and hysteretic DREQ.
module rx_stream_arbiter
    import rx_stream_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned SAMPLE_W = 13,
    parameter int unsigned LEVEL_W  = 10,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                         i_sys_clk,
    input  logic                         i_rst_b,
    input  logic [NUM_CH-1:0]            i_ch_enable,
    input  logic [NUM_CH-1:0]            i_ch_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0]   i_ch_i,
    input  logic [NUM_CH*SAMPLE_W-1:0]   i_ch_q,
    output logic                         o_fifo_push,
    output logic [WORD_W-1:0]            o_fifo_data,
    input  logic                         i_fifo_full,
    input  logic [LEVEL_W-1:0]           i_fifo_level,
    input  logic [LEVEL_W-1:0]           i_dreq_hi,
    input  logic [LEVEL_W-1:0]           i_dreq_lo,
    output logic                         o_dreq,
    input  logic                         i_clear_cnt,
    output logic [NUM_CH*CNT_W-1:0]      o_drop_cnt
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] drop_flag;
    logic [EXT_W-1:0]  hold_i   [NUM_CH];
    logic [EXT_W-1:0]  hold_q   [NUM_CH];
    logic [CNT_W-1:0]  drop_cnt [NUM_CH];

    logic [EXT_W-1:0]  ext_i_c  [NUM_CH];
    logic [EXT_W-1:0]  ext_q_c  [NUM_CH];
    logic [NUM_CH-1:0] req_c;
    logic [NUM_CH-1:0] grant_c;
    logic [NUM_CH-1:0] popped_c;
    logic [NUM_CH-1:0] load_c;
    logic [NUM_CH-1:0] drop_c;
    rx_word_t          word_c;

    // Disabled channels are masked so a stale pending bit never wins.
    assign req_c       = pending & i_ch_enable;
    assign o_fifo_push = (|req_c) & ~i_fifo_full;
    assign popped_c    = grant_c & {NUM_CH{o_fifo_push}};
    assign load_c      = i_ch_valid & i_ch_enable & (~pending | popped_c);
    assign drop_c      = i_ch_valid & i_ch_enable & ~load_c;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .clk     (i_sys_clk),
        .rst_n   (i_rst_b),
        .req     (req_c),
        .accept  (o_fifo_push),
        .grant_c (grant_c)
    );

    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            ext_i_c[k] = EXT_W'($signed(i_ch_i[k*SAMPLE_W +: SAMPLE_W]));
            ext_q_c[k] = EXT_W'($signed(i_ch_q[k*SAMPLE_W +: SAMPLE_W]));
        end
    end

    always_comb begin
        word_c = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (grant_c[k]) begin
                word_c = pack_word(CH_ID_W'(k), hold_i[k], drop_flag[k], hold_q[k]);
            end
        end
    end

    assign o_fifo_data = word_c;

    // Holding registers, sticky drop flags and saturating drop counters.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            pending   <= '0;
            drop_flag <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                hold_i[k]   <= '0;
                hold_q[k]   <= '0;
                drop_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (!i_ch_enable[k]) begin
                    pending[k] <= 1'b0;
                    hold_i[k]  <= '0;
                    hold_q[k]  <= '0;
                end else if (load_c[k]) begin
                    pending[k] <= 1'b1;
                    hold_i[k]  <= ext_i_c[k];
                    hold_q[k]  <= ext_q_c[k];
                end else if (popped_c[k]) begin
                    pending[k] <= 1'b0;
                end

                // A drop coinciding with the push re-arms the flag.
                if (i_clear_cnt) begin
                    drop_flag[k] <= 1'b0;
                end else if (drop_c[k]) begin
                    drop_flag[k] <= 1'b1;
                end else if (popped_c[k]) begin
                    drop_flag[k] <= 1'b0;
                end

                if (i_clear_cnt) begin
                    drop_cnt[k] <= '0;
                end else if (drop_c[k] && (drop_cnt[k] != '1)) begin
                    drop_cnt[k] <= drop_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
        assign o_drop_cnt[g*CNT_W +: CNT_W] = drop_cnt[g];
    end

    // Hysteretic DMA request; the set condition takes priority.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            o_dreq <= 1'b0;
        end else if (i_fifo_level >= i_dreq_hi) begin
            o_dreq <= 1'b1;
        end else if (i_fifo_level <= i_dreq_lo) begin
            o_dreq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Directed bench for rx_stream_arbiter: expected words are queued as samples
// are driven and popped when the DUT pushes.
module tb_rx_stream_arbiter;

    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned SAMPLE_W = 13;
    localparam int unsigned LEVEL_W  = 10;
    localparam int unsigned CNT_W    = 10;

    logic                       clk = 1'b0;
    logic                       rst_b = 1'b1;
    logic [NUM_CH-1:0]          ch_enable = '0;
    logic [NUM_CH-1:0]          ch_valid = '0;
    logic [NUM_CH*SAMPLE_W-1:0] ch_i = '0;
    logic [NUM_CH*SAMPLE_W-1:0] ch_q = '0;
    logic                       fifo_push;
    logic [31:0]                fifo_data;
    logic                       fifo_full = 1'b0;
    logic [LEVEL_W-1:0]         fifo_level = '0;
    logic [LEVEL_W-1:0]         dreq_hi = 10'd500;
    logic [LEVEL_W-1:0]         dreq_lo = 10'd100;
    logic                       dreq;
    logic                       clear_cnt = 1'b0;
    logic [NUM_CH*CNT_W-1:0]    drop_cnt;

    logic [31:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    rx_stream_arbiter #(
        .NUM_CH   (NUM_CH),
        .SAMPLE_W (SAMPLE_W),
        .LEVEL_W  (LEVEL_W),
        .CNT_W    (CNT_W)
    ) dut (
        .i_sys_clk    (clk),
        .i_rst_b      (rst_b),
        .i_ch_enable  (ch_enable),
        .i_ch_valid   (ch_valid),
        .i_ch_i       (ch_i),
        .i_ch_q       (ch_q),
        .o_fifo_push  (fifo_push),
        .o_fifo_data  (fifo_data),
        .i_fifo_full  (fifo_full),
        .i_fifo_level (fifo_level),
        .i_dreq_hi    (dreq_hi),
        .i_dreq_lo    (dreq_lo),
        .o_dreq       (dreq),
        .i_clear_cnt  (clear_cnt),
        .o_drop_cnt   (drop_cnt)
    );

    function automatic logic [31:0] mk(input int ch, input logic [12:0] i_s,
                                       input logic drop, input logic [12:0] q_s);
        return {1'b1, 2'(ch), i_s, 1'b0, drop, 1'b0, q_s};
    endfunction

    function automatic logic [12:0] si(input int ch, input int n);
        return (ch == 0) ? 13'(32'h100 + n) : 13'(32'h200 + n);
    endfunction

    function automatic logic [12:0] sq(input int ch, input int n);
        return (ch == 0) ? 13'(32'h1F00 + n) : 13'(32'h0E00 + n);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every push must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_b === 1'b1 && fifo_push === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_push observed=%0h expected=none", fifo_data);
            end else begin
                check("push_word", 64'(fifo_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // Reset state
        #1 rst_b = 1'b0;
        #2;
        check("rst_push", 64'(fifo_push), 64'd0);
        check("rst_dreq", 64'(dreq), 64'd0);
        check("rst_cnt", 64'(drop_cnt), 64'd0);
        tick();
        tick();
        rst_b = 1'b1;

        // Two channels strobing every cycle: alternating grants, one drop per channel every 2 cycles
        ch_enable = 2'b11;
        exp_q.push_back(mk(0, si(0, 0), 1'b0, sq(0, 0)));
        exp_q.push_back(mk(1, si(1, 0), 1'b1, sq(1, 0)));
        exp_q.push_back(mk(0, si(0, 1), 1'b1, sq(0, 1)));
        exp_q.push_back(mk(1, si(1, 2), 1'b1, sq(1, 2)));
        exp_q.push_back(mk(0, si(0, 3), 1'b1, sq(0, 3)));
        exp_q.push_back(mk(1, si(1, 4), 1'b1, sq(1, 4)));
        exp_q.push_back(mk(0, si(0, 5), 1'b1, sq(0, 5)));
        exp_q.push_back(mk(1, si(1, 6), 1'b1, sq(1, 6)));
        exp_q.push_back(mk(0, si(0, 7), 1'b0, sq(0, 7)));
        for (int n = 0; n < 8; n++) begin
            tick();
            if (n == 5) check("B_cnt_mid", 64'(drop_cnt), {44'd0, 10'd2, 10'd2});
            ch_valid = 2'b11;
            ch_i = {si(1, n), si(0, n)};
            ch_q = {sq(1, n), sq(0, n)};
        end
        tick();
        ch_valid = 2'b00;
        tick();
        tick();
        tick();
        check("B_cnt_end", 64'(drop_cnt), {44'd0, 10'd4, 10'd3});
        check("B_drained", 64'(exp_q.size()), 64'd0);

        // Single channel, strobe every 3rd cycle; disabled ch1 strobes are ignored
        ch_enable = 2'b01;
        for (int r = 0; r < 3; r++) begin
            tick();
            ch_valid = 2'b11;
            ch_i = {13'h0777, 13'h0123};
            ch_q = {13'h0555, 13'h1ABC};
            exp_q.push_back(32'h8123_1ABC);
            #1 check("A_push_strobe_cycle", 64'(fifo_push), 64'd0);
            tick();
            ch_valid = 2'b00;
            #1 check("A_push_next_cycle", 64'(fifo_push), 64'd1);
            tick();
            #1 check("A_push_idle", 64'(fifo_push), 64'd0);
        end
        check("A_cnt_kept", 64'(drop_cnt), {44'd0, 10'd4, 10'd3});

        // Backpressure: 10 full cycles with ch0 strobing
        tick();
        fifo_full = 1'b1;
        ch_valid = 2'b01;
        ch_i = {13'h0, 13'h0C00};
        ch_q = {13'h0, 13'h0C00};
        exp_q.push_back(mk(0, 13'h0C00, 1'b1, 13'h0C00));
        #1 check("C_full_push0", 64'(fifo_push), 64'd0);
        for (int n = 1; n < 10; n++) begin
            tick();
            ch_i = {13'h0, 13'(32'h0C00 + n)};
            ch_q = {13'h0, 13'(32'h0C00 + n)};
            #1 check("C_full_push", 64'(fifo_push), 64'd0);
        end
        tick();
        fifo_full = 1'b0;
        ch_i = {13'h0, 13'h0CAA};
        ch_q = {13'h0, 13'h0CAA};
        exp_q.push_back(mk(0, 13'h0CAA, 1'b0, 13'h0CAA));
        #1 check("C_release_push", 64'(fifo_push), 64'd1);
        tick();
        ch_valid = 2'b00;
        #1 check("C_second_push", 64'(fifo_push), 64'd1);
        check("C_cnt", 64'(drop_cnt), {44'd0, 10'd4, 10'd12});
        tick();
        #1 check("C_idle", 64'(fifo_push), 64'd0);

        // Saturation then clear together with a drop
        fifo_full = 1'b1;
        ch_valid = 2'b01;
        ch_i = {13'h0, 13'h0D0D};
        ch_q = {13'h0, 13'h0D0D};
        exp_q.push_back(mk(0, 13'h0D0D, 1'b0, 13'h0D0D));
        repeat (1100) tick();
        check("D_saturated", 64'(drop_cnt), {44'd0, 10'd4, 10'h3FF});
        clear_cnt = 1'b1;
        tick();
        clear_cnt = 1'b0;
        ch_valid = 2'b00;
        check("D_cleared", 64'(drop_cnt), 64'd0);
        fifo_full = 1'b0;
        #1 check("D_release_push", 64'(fifo_push), 64'd1);
        tick();
        #1 check("D_idle", 64'(fifo_push), 64'd0);

        // DREQ hysteresis hi=500 lo=100
        for (int l = 0; l <= 600; l += 20) begin
            fifo_level = LEVEL_W'(l);
            tick();
            check("E_dreq_up", 64'(dreq), 64'(l >= 500));
        end
        for (int l = 600; l >= 0; l -= 20) begin
            fifo_level = LEVEL_W'(l);
            tick();
            check("E_dreq_down", 64'(dreq), 64'(l > 100));
        end
        // hi == lo: set wins at the shared watermark
        dreq_hi = 10'd200;
        dreq_lo = 10'd200;
        for (int l = 0; l <= 400; l += 20) begin
            fifo_level = LEVEL_W'(l);
            tick();
            check("E_eq_up", 64'(dreq), 64'(l >= 200));
        end
        for (int l = 400; l >= 0; l -= 20) begin
            fifo_level = LEVEL_W'(l);
            tick();
            check("E_eq_down", 64'(dreq), 64'(l >= 200));
        end

        // Reset mid-stream with ch1 pending and FIFO full
        dreq_hi = 10'd500;
        dreq_lo = 10'd100;
        fifo_level = 10'd600;
        ch_enable = 2'b11;
        fifo_full = 1'b1;
        ch_valid = 2'b10;
        ch_i = {13'h0F0F, 13'h0};
        ch_q = {13'h0F0F, 13'h0};
        tick();
        tick();
        ch_valid = 2'b00;
        check("F_pre_dreq", 64'(dreq), 64'd1);
        check("F_pre_cnt", 64'(drop_cnt), {44'd0, 10'd1, 10'd0});
        #2;
        rst_b = 1'b0;
        fifo_full = 1'b0;
        #1;
        check("F_rst_push", 64'(fifo_push), 64'd0);
        check("F_rst_dreq", 64'(dreq), 64'd0);
        check("F_rst_cnt", 64'(drop_cnt), 64'd0);
        fifo_level = 10'd0;
        tick();
        tick();
        rst_b = 1'b1;
        ch_valid = 2'b11;
        ch_i = {si(1, 9), si(0, 9)};
        ch_q = {sq(1, 9), sq(0, 9)};
        exp_q.push_back(mk(0, si(0, 9), 1'b0, sq(0, 9)));
        exp_q.push_back(mk(1, si(1, 9), 1'b0, sq(1, 9)));
        tick();
        ch_valid = 2'b00;
        #1 check("F_first_push", 64'(fifo_push), 64'd1);
        tick();
        tick();
        tick();
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
